vram_port_arbiter: RTL and testbench

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

---
 rtl/vram_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
// Single-port VRAM arbiter between the VGA display read stream and a buffered
// CPU write stream. Display reads always win; CPU writes sit in a small FIFO
// and drain during blanking, after a one-cycle bus turnaround.
module vram_port_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              cpu_wr_valid,
   output logic              cpu_wr_ready,
   input  logic [ADDR_W-1:0] cpu_wr_addr,
   input  logic [DATA_W-1:0] cpu_wr_data,
   output logic              vram_en,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic [3:0]        fifo_level,
   output logic [15:0]       stall_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DISP,
      S_TURN,
      S_WRITE
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_beat_t;

   state_t            r_state;
   state_t            w_state_nxt;
   wr_beat_t          r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_ready_en;
   logic              r_disp_valid;
   logic [15:0]       r_stall_cnt;

   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   wr_beat_t          w_head;

   assign w_empty      = (r_level == '0);
   assign w_head       = r_fifo[r_rd_ptr];
   // Ready is held low through reset and until the first edge after release.
   assign cpu_wr_ready = r_ready_en && (r_level < LVL_FULL);
   assign w_push       = cpu_wr_valid && cpu_wr_ready;
   // Pop only when the display is not using the port; never pops an empty FIFO,
   // so a freshly pushed beat is seen no earlier than the next cycle.
   assign w_pop        = (r_state == S_WRITE) && !disp_req && !w_empty;

   assign fifo_level   = 4'(r_level);
   assign stall_cnt    = r_stall_cnt;
   assign disp_valid   = r_disp_valid;
   assign disp_data    = r_disp_valid ? vram_rdata : '0;

   // Arbiter state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: display preempts everything; writes resume only after DISP and TURN.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      if (disp_req) begin
         w_state_nxt = S_DISP;
      end else begin
         case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_WRITE;
            S_DISP:  w_state_nxt = S_TURN;
            S_TURN:  w_state_nxt = w_empty ? S_IDLE : S_WRITE;
            S_WRITE: if (w_pop && (r_level == LVL_ONE) && !w_push) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // VRAM strobe mux: display read, FIFO-head write, or an idle (all-zero) bus; silent in reset.
   always_comb begin
      vram_en    = 1'b0;
      vram_we    = 1'b0;
      vram_addr  = '0;
      vram_wdata = '0;
      if (reset) begin
         if (disp_req) begin
            vram_en   = 1'b1;
            vram_addr = disp_addr;
         end else if (w_pop) begin
            vram_en    = 1'b1;
            vram_we    = 1'b1;
            vram_addr  = w_head.addr;
            vram_wdata = w_head.data;
         end
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

   // FIFO storage.
   // NOTE: the storage array is not reset; the level and pointers alone decide which entries are live.
   always_ff @(posedge pclk) begin
      if (w_push) r_fifo[r_wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
   end

   // Saturating count of cycles where the CPU offers a beat that is refused.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (cpu_wr_valid && !cpu_wr_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Read-return flag for the cycle after a display read, and the post-reset ready enable.
   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         r_disp_valid <= 1'b0;
         r_ready_en   <= 1'b0;
      end else begin
         r_disp_valid <= disp_req;
         r_ready_en   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter
// Directed scenarios plus randomized traffic. A transaction-level model
// (queue for the write buffer, an associative array for VRAM, a cooldown
// counter for the bus turnaround) predicts every output each cycle.
module tb_vram_port_arbiter;

   localparam int AW    = 20;
   localparam int DW    = 12;
   localparam int DEPTH = 8;

   logic          pclk         = 1'b0;
   logic          reset        = 1'b0;
   logic          disp_req     = 1'b0;
   logic [AW-1:0] disp_addr    = '0;
   logic          cpu_wr_valid = 1'b0;
   logic [AW-1:0] cpu_wr_addr  = '0;
   logic [DW-1:0] cpu_wr_data  = '0;
   logic [DW-1:0] vram_rdata   = '0;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          cpu_wr_ready;
   logic          vram_en;
   logic          vram_we;
   logic [AW-1:0] vram_addr;
   logic [DW-1:0] vram_wdata;
   logic [3:0]    fifo_level;
   logic [15:0]   stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   vram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .pclk         (pclk),
      .reset        (reset),
      .disp_req     (disp_req),
      .disp_addr    (disp_addr),
      .disp_data    (disp_data),
      .disp_valid   (disp_valid),
      .cpu_wr_valid (cpu_wr_valid),
      .cpu_wr_ready (cpu_wr_ready),
      .cpu_wr_addr  (cpu_wr_addr),
      .cpu_wr_data  (cpu_wr_data),
      .vram_en      (vram_en),
      .vram_we      (vram_we),
      .vram_addr    (vram_addr),
      .vram_wdata   (vram_wdata),
      .vram_rdata   (vram_rdata),
      .fifo_level   (fifo_level),
      .stall_cnt    (stall_cnt)
   );

   initial forever #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- VRAM environment (preloaded with data = addr[11:0]) ----------------
   logic [DW-1:0] env_mem [int];
   logic [31:0]   wr_log [$];
   int            we_count = 0;

   function automatic logic [DW-1:0] env_rd(input int a);
      return env_mem.exists(a) ? env_mem[a] : a[DW-1:0];
   endfunction

   always @(posedge pclk) begin
      if (vram_en === 1'b1 && vram_we === 1'b0) vram_rdata <= env_rd(int'(vram_addr));
      if (vram_en === 1'b1 && vram_we === 1'b1) begin
         env_mem[int'(vram_addr)] = vram_wdata;
         wr_log.push_back({vram_addr, vram_wdata});
         we_count++;
      end
   end

   // ---------------- Behavioural model ----------------
   logic [31:0]   m_q [$];
   logic [DW-1:0] m_mem [int];
   int            m_cool      = 0;   // dead cycles still owed after the display releases the bus
   bit            m_engaged   = 0;   // arbiter is draining the write buffer
   bit            m_prev_read = 0;
   logic [AW-1:0] m_prev_addr = '0;
   bit            m_ready_en  = 0;
   int            m_stall     = 0;

   function automatic logic [DW-1:0] m_rd(input int a);
      return m_mem.exists(a) ? m_mem[a] : a[DW-1:0];
   endfunction

   task automatic model_cycle();
      bit            rd;
      bit            wr;
      bit            rdy;
      int            sz0;
      logic [31:0]   head;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [DW-1:0] e_ddata;
      sz0     = m_q.size();
      rd      = reset && disp_req;
      wr      = reset && !disp_req && m_engaged && (sz0 > 0);
      rdy     = reset && m_ready_en && (sz0 < DEPTH);
      head    = (sz0 > 0) ? m_q[0] : 32'h0;
      e_addr  = rd ? disp_addr : (wr ? head[31:12] : '0);
      e_wdata = wr ? head[11:0] : '0;
      e_ddata = (reset && m_prev_read) ? m_rd(int'(m_prev_addr)) : '0;
      check("disp_valid",   disp_valid,   32'(reset && m_prev_read));
      check("disp_data",    disp_data,    32'(e_ddata));
      check("vram_en",      vram_en,      32'(rd || wr));
      check("vram_we",      vram_we,      32'(wr));
      check("vram_addr",    vram_addr,    32'(e_addr));
      check("vram_wdata",   vram_wdata,   32'(e_wdata));
      check("cpu_wr_ready", cpu_wr_ready, 32'(rdy));
      check("fifo_level",   fifo_level,   32'(reset ? sz0 : 0));
      check("stall_cnt",    stall_cnt,    32'(reset ? m_stall : 0));
      if (!reset) begin
         m_q.delete();
         m_cool      = 0;
         m_engaged   = 0;
         m_prev_read = 0;
         m_prev_addr = '0;
         m_ready_en  = 0;
         m_stall     = 0;
      end else begin
         if (wr) begin
            head = m_q.pop_front();
            m_mem[int'(head[31:12])] = head[11:0];
         end
         if (cpu_wr_valid && rdy) m_q.push_back({cpu_wr_addr, cpu_wr_data});
         if (cpu_wr_valid && !rdy && m_stall < 65535) m_stall++;
         if (disp_req) begin
            m_cool    = 2;
            m_engaged = 0;
         end else if (m_cool == 2) begin
            m_cool    = 1;
            m_engaged = 0;
         end else if (m_cool == 1 || !m_engaged) begin
            m_cool    = 0;
            m_engaged = (sz0 != 0);
         end else begin
            m_engaged = (m_q.size() != 0);
         end
         m_prev_read = rd;
         m_prev_addr = disp_addr;
         m_ready_en  = 1;
      end
   endtask

   initial begin
      forever begin
         @(negedge pclk);
         model_cycle();
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic push_beat(input bit dr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      disp_req     = dr;
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = a;
      cpu_wr_data  = d;
      step();
      cpu_wr_valid = 1'b0;
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      int            dv;
      int            we_before;
      bit            mode;
      int            wr_pct;
      bit            c_disp [13];
      logic [0:5]    b_en;
      logic [AW-1:0] b_addr [6];
      logic [DW-1:0] b_wdata [6];
      int            b_level [6];

      b_en       = 6'b001110;
      b_addr     = '{20'h0, 20'h0, 20'h10, 20'h11, 20'h12, 20'h0};
      b_wdata    = '{12'h0, 12'h0, 12'hABC, 12'hDEF, 12'h123, 12'h0};
      b_level    = '{3, 3, 3, 2, 1, 0};

      // Reset with a display request pending: no strobe may escape.
      disp_req  = 1'b1;
      disp_addr = 20'd5;
      repeat (2) @(posedge pclk);
      #1;
      check("rst_vram_en", vram_en, 0);
      check("rst_ready", cpu_wr_ready, 0);
      check("rst_disp_valid", disp_valid, 0);
      step();
      reset    = 1'b1;
      disp_req = 1'b0;
      @(negedge pclk);
      check("ready_before_first_edge", cpu_wr_ready, 0);
      step();
      @(negedge pclk);
      check("ready_after_first_edge", cpu_wr_ready, 1);
      step();

      // Display-only stream over one full line.
      dv = 0;
      we_before = we_count;
      for (int i = 0; i < 1152; i++) begin
         disp_req  = 1'b1;
         disp_addr = 20'(i);
         @(negedge pclk);
         if (disp_valid === 1'b1) dv++;
         if (i == 0)    check("first_read_no_valid", disp_valid, 0);
         if (i == 1000) check("line_data_999", disp_data, 32'h3E7);
         step();
      end
      disp_req = 1'b0;
      @(negedge pclk);
      if (disp_valid === 1'b1) dv++;
      check("line_last_data", disp_data, 32'h47F);
      step();
      check("line_valid_count", dv, 1152);
      check("line_no_writes", we_count - we_before, 0);
      repeat (3) step();

      // Blanking drain of three buffered writes.
      disp_addr = 20'd500;
      push_beat(1'b1, 20'h10, 12'hABC);
      push_beat(1'b1, 20'h11, 12'hDEF);
      push_beat(1'b1, 20'h12, 12'h123);
      disp_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge pclk);
         check($sformatf("drain_en_%0d", c), vram_en, 32'(b_en[c]));
         check($sformatf("drain_addr_%0d", c), vram_addr, 32'(b_addr[c]));
         check($sformatf("drain_wdata_%0d", c), vram_wdata, 32'(b_wdata[c]));
         check($sformatf("drain_level_%0d", c), fifo_level, 32'(b_level[c]));
         step();
      end

      // Preemption of a five-entry drain after two pops.
      wr_log.delete();
      for (int i = 0; i < 5; i++) push_beat(1'b1, 20'(32'h20 + i), 12'(32'h100 + i));
      for (int c = 0; c < 13; c++) c_disp[c] = (c == 4 || c == 5);
      for (int c = 0; c < 13; c++) begin
         disp_req  = c_disp[c];
         disp_addr = 20'(32'h20 + c - 4);
         @(negedge pclk);
         if (c == 5) begin
            check("preempt_level", fifo_level, 3);
            check("preempt_read_not_write", vram_we, 0);
            check("preempt_readback", disp_data, 32'h100);
         end
         step();
      end
      check("preempt_write_count", wr_log.size(), 5);
      for (int i = 0; i < 5 && i < wr_log.size(); i++)
         check($sformatf("preempt_order_%0d", i), wr_log[i], {20'(32'h20 + i), 12'(32'h100 + i)});

      // Buffer full while the display holds the bus.
      wr_log.delete();
      disp_addr = 20'h40;
      for (int c = 1; c <= 16; c++) begin
         disp_req     = (c <= 12);
         cpu_wr_valid = 1'b1;
         cpu_wr_addr  = 20'((c <= 8) ? (32'h30 + c - 1) : 32'h38);
         cpu_wr_data  = 12'((c <= 8) ? (32'h200 + c - 1) : 32'h208);
         @(negedge pclk);
         if (c == 9) begin
            check("full_ready", cpu_wr_ready, 0);
            check("full_level", fifo_level, 8);
         end
         if (c == 15) begin
            check("full_pop_level", fifo_level, 8);
            check("full_pop_ready", cpu_wr_ready, 0);
            check("full_pop_we", vram_we, 1);
            check("full_stall_6", stall_cnt, 6);
         end
         if (c == 16) begin
            check("after_pop_level", fifo_level, 7);
            check("after_pop_ready", cpu_wr_ready, 1);
            check("full_stall_7", stall_cnt, 7);
         end
         step();
      end
      cpu_wr_valid = 1'b0;
      disp_req     = 1'b0;
      @(negedge pclk);
      check("push_pop_level_7", fifo_level, 7);
      check("stall_hold", stall_cnt, 7);
      repeat (10) step();
      check("full_drained", fifo_level, 0);
      check("full_write_count", wr_log.size(), 9);
      for (int i = 0; i < 9 && i < wr_log.size(); i++)
         check($sformatf("full_order_%0d", i), wr_log[i][31:12], 32'h30 + i);

      // Push and pop in the same cycle at level 3.
      for (int i = 0; i < 3; i++) push_beat(1'b1, 20'(32'h50 + i), 12'(32'h300 + i));
      disp_req = 1'b0;
      step();
      step();
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = 20'h53;
      cpu_wr_data  = 12'h303;
      @(negedge pclk);
      check("pp3_we", vram_we, 1);
      check("pp3_level_before", fifo_level, 3);
      step();
      cpu_wr_valid = 1'b0;
      @(negedge pclk);
      check("pp3_level_after", fifo_level, 3);
      repeat (6) step();

      // Reset in the middle of a drain.
      for (int i = 0; i < 4; i++) push_beat(1'b1, 20'(32'h60 + i), 12'(32'h400 + i));
      disp_req = 1'b0;
      step();
      step();
      #1;
      check("mid_drain_we", vram_we, 1);
      check("mid_drain_level", fifo_level, 4);
      reset    = 1'b0;
      disp_req = 1'b1;
      #1;
      check("async_vram_en", vram_en, 0);
      check("async_vram_we", vram_we, 0);
      check("async_vram_addr", vram_addr, 0);
      check("async_vram_wdata", vram_wdata, 0);
      check("async_ready", cpu_wr_ready, 0);
      check("async_level", fifo_level, 0);
      check("async_disp_valid", disp_valid, 0);
      check("async_disp_data", disp_data, 0);
      check("async_stall", stall_cnt, 0);
      we_before = we_count;
      repeat (2) @(posedge pclk);
      #1;
      reset    = 1'b1;
      disp_req = 1'b0;
      @(negedge pclk);
      check("rel_ready_low", cpu_wr_ready, 0);
      step();
      repeat (8) step();
      check("rel_level", fifo_level, 0);
      check("rel_no_writes", we_count - we_before, 0);

      // Randomized traffic, including one reset pulse.
      mode   = 1'b0;
      wr_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) wr_pct = ((c / 500) % 3 == 0) ? 95 : (((c / 500) % 3 == 1) ? 30 : 70);
         if ($urandom_range(0, 6) == 0) mode = !mode;
         disp_req     = mode;
         disp_addr    = 20'($urandom_range(0, 63));
         cpu_wr_valid = ($urandom_range(0, 99) < wr_pct);
         cpu_wr_addr  = 20'($urandom_range(0, 63));
         cpu_wr_data  = 12'($urandom_range(0, 4095));
         if (c == 1700) reset = 1'b0;
         if (c == 1703) reset = 1'b1;
         step();
      end
      disp_req     = 1'b0;
      cpu_wr_valid = 1'b0;
      repeat (20) step();
      check("final_level", fifo_level, 0);
      foreach (m_mem[k]) check($sformatf("final_mem_%0d", k), env_rd(k), m_mem[k]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
